// File: rtl/conv_pkg.sv
// conv_pkg: state encoding and width helpers shared by the convolution window sequencer
package conv_pkg;
  typedef enum logic [2:0] {IDLE, RUN, ACC, OUT, DONE} conv_seq_state_t;
  localparam int CONV_K = 3;
  localparam int CONV_N = 2;
  localparam int CONV_DATA_W = 8;
  function automatic int cfg_w(int k);
    return $clog2(k);
  endfunction
  function automatic int addr_w(int k, int n);
    return $clog2(n * n * k * k);
  endfunction
  function automatic int idx_w(int k);
    return $clog2(k * k);
  endfunction
  function automatic int pix_w(int n);
    return $clog2(n * n);
  endfunction
  function automatic int acc_w(int k, int d);
    return 2 * d + $clog2(k * k);
  endfunction
  localparam int CONV_ADDR_W = addr_w(CONV_K, CONV_N);
  localparam int CONV_IDX_W = idx_w(CONV_K);
  localparam int CONV_PIX_W = pix_w(CONV_N);
  localparam int CONV_ACC_W = acc_w(CONV_K, CONV_DATA_W);
endpackage

// File: rtl/conv_window_sequencer_decoder.sv
// decoder: maps kernel index and output pixel number to a flattened input-tile address
module decoder
  import conv_pkg::*;
#(
  parameter int K = CONV_K,
  parameter int N = CONV_N
) (
  input  logic [idx_w(K)-1:0]    index,
  input  logic [pix_w(N)-1:0]    pixel,
  input  logic [cfg_w(K)-1:0]    stride,
  input  logic [cfg_w(K)-1:0]    kw,
  output logic [addr_w(K,N)-1:0] addr
);
  logic [31:0] ke, row, col;
  always_comb begin
    ke = (kw == '0) ? 32'd1 : 32'(kw);
    row = 32'(index) / ke + 32'(stride) * (32'(pixel) / N);
    col = 32'(index) % ke + 32'(stride) * (32'(pixel) % N);
    addr = addr_w(K, N)'(row * (N * K) + col);
  end
endmodule

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: one windowed-convolution pass over an (N*K)^2 tile; define CONV_SEQ_RELU_EN to clamp results at zero
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int K = 3,
  parameter int N = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W = 2 * DATA_W + $clog2(K * K)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [cfg_w(K)-1:0]        stride,
  input  logic [cfg_w(K)-1:0]        kernel_width,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err,
  output logic                       in_rd_en,
  output logic [addr_w(K,N)-1:0]     in_rd_addr,
  input  logic signed [DATA_W-1:0]   in_rd_data,
  output logic [idx_w(K)-1:0]        wt_rd_addr,
  input  logic signed [DATA_W-1:0]   wt_rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_W-1:0]    out_data,
  output logic [pix_w(N)-1:0]        out_pixel
);
  localparam int SW = cfg_w(K);
  localparam int AW = addr_w(K, N);
  localparam int IW = idx_w(K);
  localparam int PW = pix_w(N);
  conv_seq_state_t state_q, state_d;
  logic [SW-1:0] stride_q, stride_d, kw_q, kw_d;
  logic [IW-1:0] index_q, index_d;
  logic [PW-1:0] pixel_q, pixel_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, res;
  logic signed [2*DATA_W-1:0] prod;
  logic rd_v_q, cfg_err_q, cfg_err_d;
  logic start_ok, last_idx, last_pix, run;
  logic [AW-1:0] addr;

  decoder #(.K(K), .N(N)) u_dec (
    .index (index_q),
    .pixel (pixel_q),
    .stride(stride_q),
    .kw    (kw_q),
    .addr  (addr)
  );

  assign prod = in_rd_data * wt_rd_data;
  assign start_ok = kernel_width != '0 && 32'(kernel_width) <= K;
  assign last_idx = 32'(index_q) == 32'(kw_q) * 32'(kw_q) - 32'd1;
  assign last_pix = pixel_q == PW'(N * N - 1);
  assign run = state_q == RUN;

`ifdef CONV_SEQ_RELU_EN
  assign res = acc_q[ACC_W-1] ? '0 : acc_q;
`else
  assign res = acc_q;
`endif

  always_comb begin
    state_d = state_q;
    stride_d = stride_q;
    kw_d = kw_q;
    index_d = index_q;
    pixel_d = pixel_q;
    cfg_err_d = 1'b0;
    // products land one cycle after their read strobe
    acc_d = rd_v_q ? acc_q + ACC_W'(prod) : acc_q;
    case (state_q)
      IDLE: if (start) begin
        cfg_err_d = !start_ok;
        if (start_ok) begin
          state_d = RUN;
          stride_d = stride;
          kw_d = kernel_width;
          index_d = '0;
          pixel_d = '0;
          acc_d = '0;
        end
      end
      RUN: begin
        index_d = index_q + IW'(1);
        state_d = last_idx ? ACC : RUN;
      end
      ACC: state_d = OUT;
      OUT: if (out_ready) begin
        if (last_pix) state_d = DONE;
        else begin
          state_d = RUN;
          pixel_d = pixel_q + PW'(1);
          index_d = '0;
          acc_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stride_q <= '0;
      kw_q <= '0;
      index_q <= '0;
      pixel_q <= '0;
      acc_q <= '0;
      rd_v_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stride_q <= stride_d;
      kw_q <= kw_d;
      index_q <= index_d;
      pixel_q <= pixel_d;
      acc_q <= acc_d;
      rd_v_q <= run;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign cfg_err = cfg_err_q;
  assign in_rd_en = run;
  assign in_rd_addr = run ? addr : '0;
  assign wt_rd_addr = run ? index_q : '0;
  assign out_valid = state_q == OUT;
  assign out_data = out_valid ? res : '0;
  assign out_pixel = out_valid ? pixel_q : '0;
endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer: randomized and directed passes checked against a window-sum reference model
module tb_conv_window_sequencer;
  localparam int K = 3;
  localparam int N = 2;
  localparam int ACC_W = 20;
  logic clk = 1'b0;
  logic rst_n, start, out_ready;
  logic [1:0] stride, kernel_width;
  logic busy, done, cfg_err, in_rd_en, out_valid;
  logic [5:0] in_rd_addr;
  logic [3:0] wt_rd_addr;
  logic signed [7:0] in_rd_data, wt_rd_data;
  logic signed [ACC_W-1:0] out_data;
  logic [1:0] out_pixel;
  logic signed [7:0] mem [64];
  logic signed [7:0] wts [16];
  int checks = 0, errors = 0;
  int rd_log[$], res_pix[$], res_dat[$];

  conv_window_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stride(stride), .kernel_width(kernel_width),
    .busy(busy), .done(done), .cfg_err(cfg_err), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
    .in_rd_data(in_rd_data), .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pixel(out_pixel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    in_rd_data <= mem[in_rd_addr];
    wt_rd_data <= wts[wt_rd_addr];
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int win_addr(int s, int p, int r, int c);
    return (r + s * (p / N)) * N * K + c + s * (p % N);
  endfunction

  function automatic int model_out(int kw, int s, int p);
    int acc = 0;
    logic signed [ACC_W-1:0] w;
    for (int r = 0; r < kw; r++)
      for (int c = 0; c < kw; c++)
        acc += int'(mem[win_addr(s, p, r, c)]) * int'(wts[r * kw + c]);
    w = ACC_W'(acc);
    acc = int'(w);
`ifdef CONV_SEQ_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc;
  endfunction

  task automatic run_pass(input int kw, input int s, input int sp, input int sl);
    int cyc = 0, dn = 0, busy_n = 0, stall = 0, rd_in_out = 0, unstable = 0, errs = 0;
    int done_cyc = 0, prev_v = 0, prev_pix = 0, prev_dat = 0, bad_addr = 0, i = 0;
    bit fin = 0;
    rd_log.delete(); res_pix.delete(); res_dat.delete();
    @(negedge clk);
    start = 1'b1; stride = 2'(s); kernel_width = 2'(kw); out_ready = 1'b1;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = ($urandom_range(0, 5) == 0);
      stride = 2'($urandom); kernel_width = 2'($urandom);
      busy_n += int'(busy);
      errs += int'(cfg_err);
      if (in_rd_en) rd_log.push_back(int'(in_rd_addr));
      if (out_valid && in_rd_en) rd_in_out++;
      if (out_valid && prev_v != 0 && int'(out_pixel) == prev_pix && int'(out_data) != prev_dat) unstable++;
      prev_v = int'(out_valid); prev_pix = int'(out_pixel); prev_dat = int'(out_data);
      if (out_valid) begin
        if (int'(out_pixel) == sp && stall < sl) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
          res_pix.push_back(int'(out_pixel));
          res_dat.push_back(int'(out_data));
        end
      end
      if (done) begin
        dn++; done_cyc = cyc; start = 1'b0; fin = 1;
      end
      if (cyc >= 2000) begin
        start = 1'b0; fin = 1;
      end
    end
    out_ready = 1'b1;
    check("done_count", dn, 1);
    check("done_cycle", done_cyc, N * N * (kw * kw + 2) + 1 + sl);
    check("busy_cycles", busy_n, N * N * (kw * kw + 2) + 1 + sl);
    check("cfg_err_while_busy", errs, 0);
    check("reads_during_out", rd_in_out, 0);
    check("out_stable", unstable, 0);
    check("n_outputs", res_pix.size(), N * N);
    check("n_reads", rd_log.size(), N * N * kw * kw);
    for (int p = 0; p < N * N; p++)
      for (int r = 0; r < kw; r++)
        for (int c = 0; c < kw; c++) begin
          if (i >= rd_log.size() || rd_log[i] != win_addr(s, p, r, c)) bad_addr++;
          i++;
        end
    check("addr_seq", bad_addr, 0);
    for (int p = 0; p < res_pix.size() && p < N * N; p++) begin
      check("out_pixel", res_pix[p], p);
      check("out_data", res_dat[p], model_out(kw, s, p));
    end
    @(negedge clk);
    check("done_after", int'(done), 0);
    check("busy_after", int'(busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_cfg_err"}, int'(cfg_err), 0);
    check({tag, "_rd_en"}, int'(in_rd_en), 0);
    check({tag, "_rd_addr"}, int'(in_rd_addr), 0);
    check({tag, "_wt_addr"}, int'(wt_rd_addr), 0);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_data"}, int'(out_data), 0);
    check({tag, "_pixel"}, int'(out_pixel), 0);
  endtask

  task automatic check_scn1(input string tag);
    int exp1[4] = '{14, 18, 38, 42};
    for (int p = 0; p < 4; p++)
      check(tag, (p < res_dat.size()) ? res_dat[p] : -999, exp1[p]);
  endtask

  initial begin
    int tbl[9] = '{21, 22, 23, 27, 28, 29, 33, 34, 35};
    rst_n = 1'b0; start = 1'b0; stride = '0; kernel_width = '0; out_ready = 1'b1;
    for (int a = 0; a < 64; a++) mem[a] = 8'(a);
    for (int a = 0; a < 16; a++) wts[a] = 8'sd1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_pass(2, 1, -1, 0);
    check_scn1("scn1_out");

    run_pass(3, 3, -1, 0);
    check("scn2_out3", (res_dat.size() == 4) ? res_dat[3] : -999, 252);
    for (int j = 0; j < 9; j++)
      check("scn2_addr", (rd_log.size() == 36) ? rd_log[27 + j] : -1, tbl[j]);

    for (int a = 0; a < 16; a++) wts[a] = -8'sd1;
    run_pass(2, 1, -1, 0);
`ifdef CONV_SEQ_RELU_EN
    check("neg_out0", (res_dat.size() > 0) ? res_dat[0] : -999, 0);
`else
    check("neg_out0", (res_dat.size() > 0) ? res_dat[0] : -999, -14);
`endif
    for (int a = 0; a < 16; a++) wts[a] = 8'sd1;

    run_pass(2, 1, 1, 5);
    check("stall_out1", (res_dat.size() > 1) ? res_dat[1] : -999, 18);

    @(negedge clk);
    start = 1'b1; kernel_width = 2'd0; stride = 2'd1;
    @(negedge clk);
    start = 1'b0;
    check("cfg_err_pulse", int'(cfg_err), 1);
    check("cfg_err_busy", int'(busy), 0);
    @(negedge clk);
    check("cfg_err_once", int'(cfg_err), 0);
    check("cfg_err_idle", int'(busy), 0);

    start = 1'b1; stride = 2'd1; kernel_width = 2'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_run_busy", int'(in_rd_en), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_done", int'(done), 0);
    run_pass(2, 1, -1, 0);
    check_scn1("rerun_out");

    for (int t = 0; t < 6; t++) begin
      for (int a = 0; a < 64; a++) mem[a] = 8'($urandom);
      for (int a = 0; a < 16; a++) wts[a] = 8'($urandom);
      run_pass(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
